natural_wind_gen: RTL and testbench

Parametrised natural-breeze generator for the fan controller. It produces a time-varying fan duty cycle that ramps up, holds at peak, ramps down and holds at the floor, then repeats. Ramp step, limits, tick period and hold lengths are all configurable. A built-in power toggle and mode enable let it replace the fixed natural mode in the local-mode selector, which drives the DC-motor PWM.

---
 rtl/natural_wind_gen_pkg.sv | 27 ++
 rtl/natural_wind_gen_pwm.sv | 52 +++++
 rtl/natural_wind_gen.sv | 192 +++++++++++++++++++
 tb/tb_natural_wind_gen.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/natural_wind_gen_pkg.sv
// Shared constants for the natural-breeze fan generator: FSM state codes,
// LED phase encoding and the gust LFSR seed/taps (used only when the
// NATURAL_WIND_GUST_EN build macro is defined).
package natural_wind_pkg;

   // FSM state codes
   localparam logic [2:0] ST_OFF    = 3'd0;
   localparam logic [2:0] ST_UP     = 3'd1;
   localparam logic [2:0] ST_HOLD_H = 3'd2;
   localparam logic [2:0] ST_DOWN   = 3'd3;
   localparam logic [2:0] ST_HOLD_L = 3'd4;

   // Phase encoding shown on the display LEDs; OFF shares PH_UP
   localparam logic [1:0] PH_UP     = 2'd0;
   localparam logic [1:0] PH_HOLD_H = 2'd1;
   localparam logic [1:0] PH_DOWN   = 2'd2;
   localparam logic [1:0] PH_HOLD_L = 2'd3;

   // Gust LFSR: x^16+x^14+x^13+x^11+1 in Galois (right-shift) form
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/natural_wind_gen_pwm.sv
// pwm_Nbit: N-bit PWM with RESOLUTION counts per period. A prescaler slows
// the period counter so the period approaches 1/TARGET_FREQ given CLK_FREQ.
// Output is registered, so it follows a duty change one clock later;
// duty=0 gives a constant low output.
module pwm_Nbit #(
   parameter int unsigned N           = 8,
   parameter int unsigned RESOLUTION  = 256,
   parameter int unsigned TARGET_FREQ = 100,
   parameter int unsigned CLK_FREQ    = 100_000_000
) (
   input  logic         clk,
   input  logic         reset_p,
   input  logic [N-1:0] duty,
   output logic         pwm
);

   localparam int unsigned DIV_RAW = CLK_FREQ / (TARGET_FREQ * RESOLUTION);
   localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int unsigned PW      = (DIV > 1) ? $clog2(DIV) : 1;

   logic [PW-1:0] pre_q, pre_d;
   logic [N-1:0]  cnt_q, cnt_d;
   logic          pwm_q, pwm_d;
   logic          step;

   // Prescaler and period counter advance; compare against duty
   always_comb begin
      step  = (pre_q == PW'(DIV - 1));
      pre_d = step ? '0 : pre_q + PW'(1);
      cnt_d = cnt_q;
      if (step) begin
         cnt_d = (cnt_q == N'(RESOLUTION - 1)) ? '0 : cnt_q + N'(1);
      end
      pwm_d = (cnt_q < duty);
   end

   // Counter and output registers
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         pre_q <= '0;
         cnt_q <= '0;
         pwm_q <= 1'b0;
      end else begin
         pre_q <= pre_d;
         cnt_q <= cnt_d;
         pwm_q <= pwm_d;
      end
   end

   assign pwm = pwm_q;

endmodule

// File: rtl/natural_wind_gen.sv
// natural_wind_gen: breeze-like fan duty generator. Ramps duty up to
// DUTY_MAX, holds, ramps down to DUTY_MIN, holds, repeats, one step per
// tick. btn toggles power; dropping enable parks the ramp at the floor.
// Build macro NATURAL_WIND_GUST_EN adds LFSR jitter to step size and holds.
module natural_wind_gen
   import natural_wind_pkg::*;
#(
   parameter int unsigned DUTY_W      = 8,
   parameter int unsigned DUTY_MIN    = 80,
   parameter int unsigned DUTY_MAX    = 255,
   parameter int unsigned STEP        = 25,
   parameter int unsigned TICK_CYCLES = 100_000_000,
   parameter int unsigned HOLD_HI     = 2,
   parameter int unsigned HOLD_LO     = 1,
   parameter int unsigned PWM_FREQ    = 100
) (
   input  logic              clk,
   input  logic              reset_p,
   input  logic              btn,
   input  logic              enable,
   output logic [DUTY_W-1:0] duty,
   output logic              running,
   output logic [1:0]        phase,
   output logic              pwm
);

   localparam int unsigned TCW      = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
   localparam int unsigned HOLD_MAX = (HOLD_HI > HOLD_LO) ? HOLD_HI : HOLD_LO;
   localparam int unsigned HCW      = $clog2(HOLD_MAX + 2);

   localparam logic [TCW-1:0]    TICK_LAST = TCW'(TICK_CYCLES - 1);
   localparam logic [DUTY_W-1:0] MIN_C     = DUTY_W'(DUTY_MIN);
   localparam logic [DUTY_W-1:0] MAX_C     = DUTY_W'(DUTY_MAX);
   localparam logic [DUTY_W:0]   MIN_X     = (DUTY_W+1)'(DUTY_MIN);
   localparam logic [DUTY_W:0]   MAX_X     = (DUTY_W+1)'(DUTY_MAX);
   localparam logic [DUTY_W:0]   STEP_X    = (DUTY_W+1)'(STEP);
   localparam logic [HCW-1:0]    HOLD_HI_C = HCW'(HOLD_HI);
   localparam logic [HCW-1:0]    HOLD_LO_C = HCW'(HOLD_LO);

   logic [2:0]        state_q, state_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic [TCW-1:0]    tick_cnt_q, tick_cnt_d;
   logic [HCW-1:0]    hold_cnt_q, hold_cnt_d;

   logic              active;
   logic              tick;
   logic [DUTY_W:0]   step_eff;
   logic [HCW-1:0]    hold_hi_tgt, hold_lo_tgt;
   logic [DUTY_W:0]   up_sum, dn_lim, dn_diff;
   logic [HCW-1:0]    hold_inc;

   assign running = (state_q != ST_OFF);
   assign active  = running && enable;
   assign tick    = active && (tick_cnt_q == TICK_LAST);

`ifdef NATURAL_WIND_GUST_EN
   logic [15:0] lfsr_q, lfsr_d;

   // Gust randomness: advance LFSR per tick, jitter step and hold lengths
   always_comb begin
      lfsr_d      = tick ? lfsr_next(lfsr_q) : lfsr_q;
      step_eff    = STEP_X + (DUTY_W+1)'(lfsr_q[1:0]);
      hold_hi_tgt = HOLD_HI_C + HCW'(lfsr_q[2]);
      hold_lo_tgt = HOLD_LO_C + HCW'(lfsr_q[2]);
   end

   // LFSR register
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) lfsr_q <= LFSR_SEED;
      else         lfsr_q <= lfsr_d;
   end
`else
   // Deterministic step size and hold lengths
   always_comb begin
      step_eff    = STEP_X;
      hold_hi_tgt = HOLD_HI_C;
      hold_lo_tgt = HOLD_LO_C;
   end
`endif

   // Next-state: btn beats enable-low beats tick; ramp math is done one bit
   // wider than duty so the sum cannot wrap before clamping
   always_comb begin
      state_d    = state_q;
      duty_d     = duty_q;
      hold_cnt_d = hold_cnt_q;
      up_sum     = {1'b0, duty_q} + step_eff;
      dn_lim     = MIN_X + step_eff;
      dn_diff    = {1'b0, duty_q} - step_eff;
      hold_inc   = hold_cnt_q + HCW'(1);

      if (!active || tick) tick_cnt_d = '0;
      else                 tick_cnt_d = tick_cnt_q + TCW'(1);

      if (btn) begin
         if (state_q == ST_OFF) begin
            state_d = ST_UP;
            duty_d  = MIN_C;
         end else begin
            state_d = ST_OFF;
            duty_d  = '0;
         end
         tick_cnt_d = '0;
         hold_cnt_d = '0;
      end else if (running && !enable) begin
         state_d    = ST_UP;
         duty_d     = MIN_C;
         tick_cnt_d = '0;
         hold_cnt_d = '0;
      end else if (tick) begin
         case (state_q)
            ST_UP: begin
               if (up_sum >= MAX_X) begin
                  duty_d  = MAX_C;
                  state_d = (HOLD_HI == 0) ? ST_DOWN : ST_HOLD_H;
               end else begin
                  duty_d = up_sum[DUTY_W-1:0];
               end
            end
            ST_HOLD_H: begin
               if (hold_inc >= hold_hi_tgt) begin
                  hold_cnt_d = '0;
                  state_d    = ST_DOWN;
               end else begin
                  hold_cnt_d = hold_inc;
               end
            end
            ST_DOWN: begin
               if ({1'b0, duty_q} > dn_lim) begin
                  duty_d = dn_diff[DUTY_W-1:0];
               end else begin
                  duty_d  = MIN_C;
                  state_d = (HOLD_LO == 0) ? ST_UP : ST_HOLD_L;
               end
            end
            ST_HOLD_L: begin
               if (hold_inc >= hold_lo_tgt) begin
                  hold_cnt_d = '0;
                  state_d    = ST_UP;
               end else begin
                  hold_cnt_d = hold_inc;
               end
            end
            default: begin
               state_d = ST_OFF;
               duty_d  = '0;
            end
         endcase
      end
   end

   // State, duty and counter registers
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         state_q    <= ST_OFF;
         duty_q     <= '0;
         tick_cnt_q <= '0;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         duty_q     <= duty_d;
         tick_cnt_q <= tick_cnt_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   // LED phase decode of the registered state
   always_comb begin
      case (state_q)
         ST_HOLD_H: phase = PH_HOLD_H;
         ST_DOWN:   phase = PH_DOWN;
         ST_HOLD_L: phase = PH_HOLD_L;
         default:   phase = PH_UP;
      endcase
   end

   assign duty = duty_q;

   // TICK_CYCLES is one second of clk, so it doubles as the clock rate
   pwm_Nbit #(
      .N           (DUTY_W),
      .RESOLUTION  (2 ** DUTY_W),
      .TARGET_FREQ (PWM_FREQ),
      .CLK_FREQ    (TICK_CYCLES)
   ) u_pwm (
      .clk     (clk),
      .reset_p (reset_p),
      .duty    (duty_q),
      .pwm     (pwm)
   );

endmodule

// File: tb/tb_natural_wind_gen.sv
// Directed bench for natural_wind_gen. Four instances share clk/reset/btn/
// enable: A (STEP 25), B (STEP 50), C (STEP 175, no holds), D (STEP 175,
// long high hold for a steady-255 PWM window). TICK_CYCLES=4 throughout.
module tb_natural_wind_gen;

   logic clk = 1'b0;
   logic reset_p, btn, enable;

   logic [7:0] duty_a, duty_b, duty_c, duty_d;
   logic       run_a, run_b, run_c, run_d;
   logic [1:0] ph_a, ph_b, ph_c, ph_d;
   logic       pwm_a, pwm_b, pwm_c, pwm_d;

   int n_cmp = 0;
   int n_err = 0;

   natural_wind_gen #(.DUTY_W(8), .DUTY_MIN(80), .DUTY_MAX(255), .STEP(25),
      .TICK_CYCLES(4), .HOLD_HI(2), .HOLD_LO(1), .PWM_FREQ(100)) u_a (
      .clk(clk), .reset_p(reset_p), .btn(btn), .enable(enable),
      .duty(duty_a), .running(run_a), .phase(ph_a), .pwm(pwm_a));

   natural_wind_gen #(.DUTY_W(8), .DUTY_MIN(80), .DUTY_MAX(255), .STEP(50),
      .TICK_CYCLES(4), .HOLD_HI(2), .HOLD_LO(1), .PWM_FREQ(100)) u_b (
      .clk(clk), .reset_p(reset_p), .btn(btn), .enable(enable),
      .duty(duty_b), .running(run_b), .phase(ph_b), .pwm(pwm_b));

   natural_wind_gen #(.DUTY_W(8), .DUTY_MIN(80), .DUTY_MAX(255), .STEP(175),
      .TICK_CYCLES(4), .HOLD_HI(0), .HOLD_LO(0), .PWM_FREQ(100)) u_c (
      .clk(clk), .reset_p(reset_p), .btn(btn), .enable(enable),
      .duty(duty_c), .running(run_c), .phase(ph_c), .pwm(pwm_c));

   natural_wind_gen #(.DUTY_W(8), .DUTY_MIN(80), .DUTY_MAX(255), .STEP(175),
      .TICK_CYCLES(4), .HOLD_HI(100), .HOLD_LO(0), .PWM_FREQ(100)) u_d (
      .clk(clk), .reset_p(reset_p), .btn(btn), .enable(enable),
      .duty(duty_d), .running(run_d), .phase(ph_d), .pwm(pwm_d));

   initial forever #5 clk = ~clk;

   // Expected duty/phase after k ticks following power-on
   int exp_a_d [11] = '{80, 105, 130, 155, 180, 205, 230, 255, 255, 255, 230};
   int exp_a_p [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 2};
   int exp_b_d [13] = '{80, 130, 180, 230, 255, 255, 255, 205, 155, 105, 80, 80, 130};
   int exp_b_p [13] = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 2, 3, 0, 0};
   int exp_c_d [13] = '{80, 255, 80, 255, 80, 255, 80, 255, 80, 255, 80, 255, 80};
   int exp_c_p [13] = '{0, 2, 0, 2, 0, 2, 0, 2, 0, 2, 0, 2, 0};

   task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic pulse_btn();
      @(negedge clk) btn = 1'b1;
      @(negedge clk) btn = 1'b0;
   endtask

   initial begin
      int hi_cnt;
      int nz_cnt;
      reset_p = 1'b1;
      btn     = 1'b0;
      enable  = 1'b1;

      // Reset state
      #3;
      chk_val("rst_duty",  duty_a, 0);
      chk_val("rst_run",   run_a,  0);
      chk_val("rst_phase", ph_a,   0);
      chk_val("rst_pwm",   pwm_a,  0);
      repeat (2) @(negedge clk);
      reset_p = 1'b0;
      repeat (3) @(negedge clk);
      chk_val("idle_duty", duty_a, 0);

      // Power on; ramp/hold sequences of A, B and C
      pulse_btn();
      chk_val("on_run", run_a, 1);
      for (int k = 0; k <= 12; k++) begin
         if (k > 0) repeat (4) @(negedge clk);
         if (k <= 10) begin
            chk_val($sformatf("a_duty_t%0d", k), duty_a, exp_a_d[k]);
            chk_val($sformatf("a_phase_t%0d", k), ph_a, exp_a_p[k]);
         end
         chk_val($sformatf("b_duty_t%0d", k), duty_b, exp_b_d[k]);
         chk_val($sformatf("b_phase_t%0d", k), ph_b, exp_b_p[k]);
         chk_val($sformatf("c_duty_t%0d", k), duty_c, exp_c_d[k]);
         chk_val($sformatf("c_phase_t%0d", k), ph_c, exp_c_p[k]);
      end

      // D holds 255 long enough to see a full 256-cycle PWM period
      hi_cnt = 0;
      repeat (256) begin
         @(negedge clk);
         if (pwm_d) hi_cnt++;
      end
      chk_val("d_duty_hold", duty_d, 255);
      chk_val("d_phase_hold", ph_d, 1);
      chk_val("d_pwm_hi_ge255", (hi_cnt >= 255), 1);

      // Enable dropped for one cycle at duty 205
      @(negedge clk) reset_p = 1'b1;
      @(negedge clk) reset_p = 1'b0;
      pulse_btn();
      repeat (20) @(negedge clk);
      chk_val("s3_pre_duty", duty_a, 205);
      enable = 1'b0;
      @(negedge clk) enable = 1'b1;
      chk_val("s3_floor_duty", duty_a, 80);
      chk_val("s3_floor_phase", ph_a, 0);
      chk_val("s3_still_run", run_a, 1);
      repeat (3) @(negedge clk);
      chk_val("s3_no_early_tick", duty_a, 80);
      @(negedge clk);
      chk_val("s3_first_tick", duty_a, 105);

      // Power off at duty 230, stays off, power back on
      repeat (20) @(negedge clk);
      chk_val("s4_pre_duty", duty_a, 230);
      pulse_btn();
      chk_val("s4_off_duty", duty_a, 0);
      chk_val("s4_off_run", run_a, 0);
      nz_cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (duty_a != 8'd0) nz_cnt++;
      end
      chk_val("s4_stays_off", nz_cnt, 0);
      chk_val("s4_off_pwm", pwm_a, 0);
      pulse_btn();
      chk_val("s4_on_again", duty_a, 80);

      // btn lands on the same edge as a tick: off wins
      repeat (3) @(negedge clk);
      btn = 1'b1;
      @(negedge clk) btn = 1'b0;
      chk_val("s5_btn_tick_duty", duty_a, 0);
      chk_val("s5_btn_tick_run", run_a, 0);

      // Asynchronous reset mid-ramp
      pulse_btn();
      repeat (8) @(negedge clk);
      chk_val("s5_mid_duty", duty_a, 130);
      #2 reset_p = 1'b1;
      #1;
      chk_val("s5_async_duty", duty_a, 0);
      chk_val("s5_async_pwm", pwm_a, 0);
      chk_val("s5_async_run", run_a, 0);
      chk_val("s5_async_phase", ph_a, 0);
      @(negedge clk) reset_p = 1'b0;
      repeat (6) @(negedge clk);
      chk_val("s5_post_rst_duty", duty_a, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
